offset_multiplier_recon: RTL
============================

// Module: offset_multiplier_recon
// PURPOSE
//  Dequantizer-side inverse of the offset divider: rebuilds dividend = quotient*divisor + remainder.
//  Sequential shift-add. Each cycle adds one divisor<<k term, for the highest remaining set quotient bit k.
//  Latency scales with popcount(quotient), mirroring the divider's one-cycle-per-set-bit cost.
//  Sits after the quantized-symbol decode stage; feeds reconstructed values to the dequantizer output path.
// PARAMETERS
//  dividendWidth  10  width of the nominal reconstructed value and of remainder
//  divisorWidth    9  width of divisor
//  quotientWidth   6  width of quotient
//  LODWidth        4  width of leading-one index into quotient; must satisfy 2^LODWidth >= quotientWidth
//  reconWidth     16  accumulator/output width = quotientWidth+divisorWidth+1 (never wraps)
// PORTS
//  clk            in   1              rising-edge clock
//  rst            in   1              synchronous, active-high reset
//  start          in   1              load operands and begin; accepted only in IDLE or DONE
//  quotient       in   quotientWidth  operand, sampled on accepted start
//  divisor        in   divisorWidth   operand, sampled on accepted start
//  remainder      in   dividendWidth  operand, sampled on accepted start; initial accumulator value
//  reconstructed  out  reconWidth     result; valid while ready=1
//  overflow       out  1              result > 2^dividendWidth-1; valid while ready=1
//  busy           out  1              1 in ACCUM
//  ready          out  1              1 in DONE; held until the next accepted start
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - state=IDLE; reconstructed=0, overflow=0, busy=0, ready=0; internal q_rem/d_reg cleared.
//   - Reset wins over start in the same cycle.
//   - Reset mid-ACCUM aborts the operation with no result.
//  IDLE, start=1: q_rem<=quotient, d_reg<=divisor, acc<=zero-extended remainder; busy<=1; ->ACCUM.
//  ACCUM, q_rem!=0:
//   - k = leading-one index of q_rem.
//   - acc <= acc + ({zeros,d_reg}<<k); clear bit k of q_rem; stay in ACCUM.
//  ACCUM, q_rem==0:
//   - reconstructed<=acc; overflow<=(acc>>dividendWidth)!=0; busy<=0; ready<=1; ->DONE.
//  DONE:
//   - Outputs held stable.
//   - start=1: ready<=0, reload operands as in IDLE, ->ACCUM. Back-to-back issue allowed.
//  start during ACCUM: ignored; operands not resampled.
//  Latency: accepted start at edge T -> ready=1 after edge T+popcount(quotient)+1.
//   - q=0: 1 cycle. q=all-ones: quotientWidth+1 cycles.
//  Arithmetic: all unsigned. Adds carried in reconWidth bits; no truncation, no saturation. overflow is advisory only.
//  divisor=0: still one cycle per set bit; result=remainder.
//  reconstructed keeps its previous value while busy; consumers must qualify it with ready.
// STRUCTURE
//  Shared package offset_codec_pkg:
//   - width constants (dividendWidth, divisorWidth, quotientWidth, LODWidth, reconWidth);
//   - state enum {IDLE, ACCUM, DONE}, 2 bits.
//  Sub-module quotient_leading_one_detect:
//   - combinational, quotientWidth in -> LODWidth index + any_one flag.
//   - Index is don't-care when any_one=0.
//  Top holds the FSM, acc, q_rem and d_reg registers, the shifter and the adder.
// TESTING
//  1. q=0,d=5,r=3, start 1 cycle -> ready after 1 cycle, reconstructed=3, overflow=0.
//  2. q=45(101101b),d=9,r=7 -> 4 add cycles, ready at T+5, reconstructed=412, overflow=0.
//  3. q=63,d=511,r=1023 -> ready at T+7, reconstructed=33216, overflow=1.
//  4. Round trip with the divider: dividend=1000, divisor=37 -> q=27,r=1 -> reconstructed=1000.
//  5. start re-pulsed mid-ACCUM with different operands -> ignored; result of first op.
//     Then start in DONE -> new op; ready drops next cycle.
//  6. rst asserted 2 cycles into q=63 op -> next cycle busy=0, ready=0, reconstructed=0.
//     A subsequent op then completes correctly.

Source files
------------

// File: rtl/offset_codec_pkg.sv
// rtl/offset_codec_pkg.sv - shared widths and FSM state encoding for the offset codec
package offset_codec_pkg;
  localparam int dividendWidth = 10;
  localparam int divisorWidth  = 9;
  localparam int quotientWidth = 6;
  localparam int LODWidth      = 4;
  localparam int reconWidth    = quotientWidth + divisorWidth + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/quotient_leading_one_detect.sv
// rtl/quotient_leading_one_detect.sv - index of the highest set quotient bit
// o_index is meaningless when o_any_one is low.
module quotient_leading_one_detect
  import offset_codec_pkg::*;
(
  input  logic [quotientWidth-1:0] i_quotient,
  output logic [LODWidth-1:0]      o_index,
  output logic                     o_any_one
);

  always_comb begin
    o_index   = '0;
    o_any_one = 1'b0;
    // Ascending scan so the last hit, the highest bit, wins
    for (int i = 0; i < quotientWidth; i++) begin
      if (i_quotient[i]) begin
        o_index   = LODWidth'(i);
        o_any_one = 1'b1;
      end
    end
  end

endmodule

// File: rtl/offset_multiplier_recon.sv
// rtl/offset_multiplier_recon.sv - shift-add rebuild of dividend = quotient*divisor + remainder
// One divisor<<k term is added per cycle for each set quotient bit, highest first.
module offset_multiplier_recon
  import offset_codec_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [quotientWidth-1:0] i_quotient,
  input  logic [divisorWidth-1:0]  i_divisor,
  input  logic [dividendWidth-1:0] i_remainder,
  output logic [reconWidth-1:0]    o_reconstructed,
  output logic                     o_overflow,
  output logic                     o_busy,
  output logic                     o_ready
);

  state_t                   r_state;
  state_t                   w_next_state;
  logic [quotientWidth-1:0] r_q_rem;
  logic [divisorWidth-1:0]  r_d_reg;
  logic [reconWidth-1:0]    r_acc;
  logic [reconWidth-1:0]    r_recon;
  logic                     r_overflow;
  logic                     r_busy;
  logic                     r_ready;

  logic [LODWidth-1:0]      w_lod_index;
  logic                     w_any_one;
  logic [reconWidth-1:0]    w_term;
  logic [quotientWidth-1:0] w_clear_mask;
  logic                     w_load;
  logic                     w_step;
  logic                     w_finish;

  quotient_leading_one_detect u_lod (
    .i_quotient (r_q_rem),
    .o_index    (w_lod_index),
    .o_any_one  (w_any_one)
  );

  // Accumulator is wide enough for the full product plus remainder, so no wrap
  assign w_term       = reconWidth'(r_d_reg) << w_lod_index;
  assign w_clear_mask = quotientWidth'(1) << w_lod_index;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (i_start) begin
          w_load       = 1'b1;
          w_next_state = ACCUM;
        end
      end
      ACCUM: begin
        if (w_any_one) begin
          w_step = 1'b1;
        end else begin
          w_finish     = 1'b1;
          w_next_state = DONE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q_rem    <= '0;
      r_d_reg    <= '0;
      r_acc      <= '0;
      r_recon    <= '0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
      r_ready    <= 1'b0;
    end else if (w_load) begin
      r_q_rem <= i_quotient;
      r_d_reg <= i_divisor;
      r_acc   <= reconWidth'(i_remainder);
      r_busy  <= 1'b1;
      r_ready <= 1'b0;
    end else if (w_step) begin
      r_acc   <= r_acc + w_term;
      r_q_rem <= r_q_rem & ~w_clear_mask;
    end else if (w_finish) begin
      r_recon    <= r_acc;
      r_overflow <= (r_acc >> dividendWidth) != '0;
      r_busy     <= 1'b0;
      r_ready    <= 1'b1;
    end
  end

  assign o_reconstructed = r_recon;
  assign o_overflow      = r_overflow;
  assign o_busy          = r_busy;
  assign o_ready         = r_ready;

endmodule
